dest_reg_pipe: RTL and testbench

DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

---
 rtl/dest_reg_pipe.sv | 87 ++++++++
 tb/tb_dest_reg_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dest_reg_pipe.sv
// Destination-register tracking through ID/EX, EX/MEM and MEM/WB.
// Produces the load-use stall and the EX operand forward selects.
module dest_reg_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_dst,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       flush,
    output logic [4:0] ex_dst,
    output logic [4:0] mem_dst,
    output logic [4:0] wb_dst,
    output logic       ex_regwrite,
    output logic       mem_regwrite,
    output logic       wb_regwrite,
    output logic       load_stall,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_memread;
    logic       bubble;
    logic       mem_live;
    logic       wb_live;

    assign bubble = load_stall | flush;

    // ID/EX: a stall or squash inserts an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_rs       <= 5'd0;
            ex_rt       <= 5'd0;
            ex_dst      <= 5'd0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
        end else begin
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_dst      <= id_dst;
            ex_regwrite <= id_regwrite;
            ex_memread  <= id_memread;
        end
    end

    // Older stages always advance so in-flight instructions complete
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dst      <= 5'd0;
            mem_regwrite <= 1'b0;
            wb_dst       <= 5'd0;
            wb_regwrite  <= 1'b0;
        end else begin
            mem_dst      <= ex_dst;
            mem_regwrite <= ex_regwrite;
            wb_dst       <= mem_dst;
            wb_regwrite  <= mem_regwrite;
        end
    end

    assign load_stall = ex_memread & (ex_dst != 5'd0) &
                        ((ex_dst == id_rs) | (ex_dst == id_rt));

    // Register $0 is hardwired, so a producer targeting it never forwards
    assign mem_live = mem_regwrite & (mem_dst != 5'd0);
    assign wb_live  = wb_regwrite & (wb_dst != 5'd0);

    always_comb begin
        fwd_a = 2'b00;
        if (mem_live && (mem_dst == ex_rs))
            fwd_a = 2'b10;
        else if (wb_live && (wb_dst == ex_rs))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (mem_live && (mem_dst == ex_rt))
            fwd_b = 2'b10;
        else if (wb_live && (wb_dst == ex_rt))
            fwd_b = 2'b01;
    end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe: reset, pipeline latency, forwarding,
// load-use stall, $0 rule, flush/stall interaction and reset mid-stall.
module tb_dest_reg_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_regwrite, id_memread, flush;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       ex_regwrite, mem_regwrite, wb_regwrite;
    logic       load_stall;
    logic [1:0] fwd_a, fwd_b;

    int n_checks = 0;
    int n_errors = 0;

    dest_reg_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dst       (id_dst),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .flush        (flush),
        .ex_dst       (ex_dst),
        .mem_dst      (mem_dst),
        .wb_dst       (wb_dst),
        .ex_regwrite  (ex_regwrite),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .load_stall   (load_stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic rw, input logic mr);
        id_rs       = rs;
        id_rt       = rt;
        id_dst      = dst;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_dst"},  {3'b0, ex_dst},  8'd0);
        check({tag, ".mem_dst"}, {3'b0, mem_dst}, 8'd0);
        check({tag, ".wb_dst"},  {3'b0, wb_dst},  8'd0);
        check({tag, ".rw"},      {5'b0, ex_regwrite, mem_regwrite, wb_regwrite}, 8'd0);
        check({tag, ".stall"},   {7'b0, load_stall}, 8'd0);
        check({tag, ".fwd"},     {4'b0, fwd_a, fwd_b}, 8'd0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        issue(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
        tick();
        issue(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        issue(0, 0, 0, 0, 0);
        #1;
        check_all_zero("reset");

        // Pipeline latency: dst=5 appears at ex, mem, wb on successive cycles
        issue(0, 0, 5, 1, 0);
        tick();
        check("pipe.ex_dst", {3'b0, ex_dst}, 8'd5);
        check("pipe.ex_rw",  {7'b0, ex_regwrite}, 8'd1);
        check("pipe.mem_dst_early", {3'b0, mem_dst}, 8'd0);
        issue(0, 0, 0, 0, 0);
        tick();
        check("pipe.mem_dst", {3'b0, mem_dst}, 8'd5);
        check("pipe.ex_cleared", {3'b0, ex_dst}, 8'd0);
        tick();
        check("pipe.wb_dst", {3'b0, wb_dst}, 8'd5);
        check("pipe.wb_rw",  {7'b0, wb_regwrite}, 8'd1);
        tick();
        tick();

        // Two writes to $8 in flight: youngest (EX/MEM) wins
        issue(0, 0, 8, 1, 0);
        tick();
        issue(0, 0, 8, 1, 0);
        tick();
        issue(8, 3, 0, 0, 0);
        tick();
        check("prio.fwd_a", {6'b0, fwd_a}, 8'd2);
        check("prio.fwd_b", {6'b0, fwd_b}, 8'd0);

        // Only the older write in flight: forward from MEM/WB
        issue(0, 0, 8, 1, 0);
        tick();
        issue(0, 0, 0, 0, 0);
        tick();
        issue(8, 8, 0, 0, 0);
        tick();
        check("older.fwd_a", {6'b0, fwd_a}, 8'd1);
        check("older.fwd_b", {6'b0, fwd_b}, 8'd1);

        // Load-use on rt: one stall cycle, bubble, then forward from MEM/WB
        issue(0, 0, 9, 1, 1);
        tick();
        issue(0, 9, 10, 1, 0);
        #1;
        check("lu.stall", {7'b0, load_stall}, 8'd1);
        tick();
        check("lu.bubble_rw",  {7'b0, ex_regwrite}, 8'd0);
        check("lu.bubble_dst", {3'b0, ex_dst}, 8'd0);
        check("lu.stall_drop", {7'b0, load_stall}, 8'd0);
        check("lu.mem_dst",    {3'b0, mem_dst}, 8'd9);
        tick();
        check("lu.reader_ex", {3'b0, ex_dst}, 8'd10);
        check("lu.fwd_b", {6'b0, fwd_b}, 8'd1);
        check("lu.fwd_a", {6'b0, fwd_a}, 8'd0);

        // $0 destination never stalls or forwards
        issue(0, 0, 0, 1, 1);
        tick();
        issue(0, 0, 0, 0, 0);
        #1;
        check("zero.stall", {7'b0, load_stall}, 8'd0);
        tick();
        check("zero.mem_rw", {7'b0, mem_regwrite}, 8'd1);
        check("zero.fwd_a", {6'b0, fwd_a}, 8'd0);
        check("zero.fwd_b", {6'b0, fwd_b}, 8'd0);

        // Flush together with stall: exactly one bubble, older stages advance
        issue(0, 0, 12, 1, 1);
        tick();
        issue(12, 0, 13, 1, 0);
        flush = 1'b1;
        #1;
        check("fs.stall", {7'b0, load_stall}, 8'd1);
        tick();
        flush = 1'b0;
        check("fs.bubble_dst", {3'b0, ex_dst}, 8'd0);
        check("fs.bubble_rw",  {7'b0, ex_regwrite}, 8'd0);
        check("fs.mem_dst",    {3'b0, mem_dst}, 8'd12);
        check("fs.mem_rw",     {7'b0, mem_regwrite}, 8'd1);
        check("fs.stall_drop", {7'b0, load_stall}, 8'd0);
        tick();
        check("fs.reader_ex", {3'b0, ex_dst}, 8'd13);
        check("fs.wb_dst",    {3'b0, wb_dst}, 8'd12);
        check("fs.fwd_a",     {6'b0, fwd_a}, 8'd1);

        // Flush alone squashes the decode instruction but not older ones
        issue(0, 0, 7, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl.ex_rw",   {7'b0, ex_regwrite}, 8'd0);
        check("fl.mem_dst", {3'b0, mem_dst}, 8'd13);

        // Reset in the middle of a stall leaves no residue
        issue(0, 0, 14, 1, 1);
        tick();
        issue(0, 14, 15, 1, 0);
        #1;
        check("rs.stall", {7'b0, load_stall}, 8'd1);
        rst = 1'b1;
        tick();
        check_all_zero("rs.cleared");
        rst = 1'b0;
        tick();
        check("rs.reader_ex", {3'b0, ex_dst}, 8'd15);
        check("rs.fwd_b", {6'b0, fwd_b}, 8'd0);
        check("rs.stall_after", {7'b0, load_stall}, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
